// File: rtl/aes_bus_master_if.sv
// -----------------------------------------------------------------------------
// aes_bus_master_if
//
// Purpose:
//   Byte-serial CS/RW/adress bus between the host-side bus master and the
//   AES128 core-side interface FSM.
//
// Signals:
//   cs        chip select; a beat happens in every cycle with cs=1
//   rw        1 = write beat (master -> core), 0 = read beat (core -> master)
//   adress    1 = key shift register, 0 = message/result shift register
//   data_out  write data from the master; 0 whenever the master is not writing
//   data_in   read data from the core; meaningful in cycles with cs=1, rw=0
//
// Modports:
//   master    drives cs/rw/adress/data_out, receives data_in
//   slave     receives cs/rw/adress/data_out, drives data_in
// -----------------------------------------------------------------------------
interface aes_bus_master_if #(
  parameter int BUS_W = 8
);

  logic             cs;
  logic             rw;
  logic             adress;
  logic [BUS_W-1:0] data_out;
  logic [BUS_W-1:0] data_in;

  modport master (
    output cs,
    output rw,
    output adress,
    output data_out,
    input  data_in
  );

  modport slave (
    input  cs,
    input  rw,
    input  adress,
    input  data_out,
    output data_in
  );

endinterface : aes_bus_master_if

// File: rtl/aes_bus_master.sv
// -----------------------------------------------------------------------------
// aes_bus_master
//
// Purpose:
//   Host-side initiator for the AES128 core's byte-serial bus. One accepted
//   start runs a full transaction:
//     - key written as 16 beats, MSB byte first (adress=1)
//     - message written as 16 beats, MSB byte first (adress=0)
//     - one LOAD cycle with cs=0, rw=1 that triggers the core
//     - WAIT_CYCLES idle cycles while the core encrypts
//     - ciphertext read as 16 beats, shifted into result from the LSB end
//     - one DONE cycle with a done pulse
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_start      one-cycle request, only honoured in IDLE
//   i_key_reuse  (AES_KEY_REUSE_EN only) skip the key phase, sampled with start
//   i_key_in     AES key, snapshotted when start is accepted
//   i_msg_in     plaintext, snapshotted when start is accepted
//   o_busy       high from the cycle after acceptance through the DONE cycle
//   o_done       one-cycle pulse, result valid from this cycle
//   o_result     ciphertext, updated only during read beats, held otherwise
//   bus          master side of aes_bus_master_if
//
// Configuration:
//   AES_KEY_REUSE_EN  when defined, adds i_key_reuse; a start with
//                     i_key_reuse=1 goes straight to the message phase so
//                     the core keeps its previously loaded key.
//
// Parameters:
//   BUS_W        bus width, fixed at 8 (16 beats per 128-bit block)
//   WAIT_CYCLES  idle cycles between LOAD and the first read beat, >= 1
//
// All bus outputs, busy and done come straight from flops.
// -----------------------------------------------------------------------------
module aes_bus_master #(
  parameter int BUS_W       = 8,
  parameter int WAIT_CYCLES = 12
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
`ifdef AES_KEY_REUSE_EN
  input  logic                  i_key_reuse,
`endif
  input  logic [127:0]          i_key_in,
  input  logic [127:0]          i_msg_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [127:0]          o_result,
  aes_bus_master_if.master      bus
);

  // ---------------------------------------------------------------------------
  // state      | meaning
  // -----------+---------------------------------------------------------------
  // S_IDLE     | waiting for start; bus quiet
  // S_WR_KEY   | 16 key write beats, adress=1
  // S_WR_MSG   | 16 message write beats, adress=0
  // S_LOAD     | single cs=0, rw=1 cycle that triggers the core load
  // S_WAIT     | WAIT_CYCLES quiet cycles while the core encrypts
  // S_RD       | 16 read beats, data_in shifted into result
  // S_DONE     | done pulse; back to idle next cycle, start ignored here
  // ---------------------------------------------------------------------------

  localparam int BEATS  = 128 / BUS_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_KEY,
    S_WR_MSG,
    S_LOAD,
    S_WAIT,
    S_RD,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_beat;
  logic [WAIT_W-1:0]   r_wait;
  logic [127:0]        r_key;
  logic [127:0]        r_msg;
  logic [127:0]        r_result;
  logic                r_cs;
  logic                r_rw;
  logic                r_adress;
  logic [BUS_W-1:0]    r_data_out;
  logic                r_busy;
  logic                r_done;

  logic                w_skip_key;
  logic                w_last_beat;
  logic [CNT_W-1:0]    w_beat_nxt;

`ifdef AES_KEY_REUSE_EN
  assign w_skip_key = i_key_reuse;
`else
  assign w_skip_key = 1'b0;
`endif

  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_beat_nxt  = r_beat + CNT_W'(1);

  // Beat n of a block is byte n counted from the MSB end.
  function automatic logic [BUS_W-1:0] f_beat(input logic [127:0]     blk,
                                              input logic [CNT_W-1:0] idx);
    f_beat = blk[BUS_W*(BEATS-1-int'(idx)) +: BUS_W];
  endfunction

  // Outputs are registered alongside the state: each branch sets the bus
  // values for the cycle in which the next state is current.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_wait     <= '0;
      r_key      <= '0;
      r_msg      <= '0;
      r_result   <= '0;
      r_cs       <= 1'b0;
      r_rw       <= 1'b0;
      r_adress   <= 1'b0;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_key  <= i_key_in;
            r_msg  <= i_msg_in;
            r_beat <= '0;
            r_busy <= 1'b1;
            r_cs   <= 1'b1;
            r_rw   <= 1'b1;
            // The first beat comes from the live inputs since the snapshot
            // is only being written on this edge.
            if (w_skip_key) begin
              r_state    <= S_WR_MSG;
              r_adress   <= 1'b0;
              r_data_out <= f_beat(i_msg_in, '0);
            end else begin
              r_state    <= S_WR_KEY;
              r_adress   <= 1'b1;
              r_data_out <= f_beat(i_key_in, '0);
            end
          end
        end

        S_WR_KEY: begin
          if (w_last_beat) begin
            r_state    <= S_WR_MSG;
            r_beat     <= '0;
            r_adress   <= 1'b0;
            r_data_out <= f_beat(r_msg, '0);
          end else begin
            r_beat     <= w_beat_nxt;
            r_data_out <= f_beat(r_key, w_beat_nxt);
          end
        end

        S_WR_MSG: begin
          if (w_last_beat) begin
            // LOAD keeps rw=1 with cs dropped; that edge is the core's trigger.
            r_state    <= S_LOAD;
            r_beat     <= '0;
            r_cs       <= 1'b0;
            r_rw       <= 1'b1;
            r_adress   <= 1'b0;
            r_data_out <= '0;
          end else begin
            r_beat     <= w_beat_nxt;
            r_data_out <= f_beat(r_msg, w_beat_nxt);
          end
        end

        S_LOAD: begin
          r_state <= S_WAIT;
          r_rw    <= 1'b0;
          r_wait  <= WAIT_LOAD;
        end

        S_WAIT: begin
          if (r_wait == '0) begin
            r_state  <= S_RD;
            r_beat   <= '0;
            r_cs     <= 1'b1;
            r_rw     <= 1'b0;
            r_adress <= 1'b0;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end

        S_RD: begin
          // After 16 shifts the first byte read sits in result[127:120].
          r_result <= {r_result[127-BUS_W:0], bus.data_in};
          if (w_last_beat) begin
            r_state <= S_DONE;
            r_beat  <= '0;
            r_cs    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_beat <= w_beat_nxt;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_beat     <= '0;
          r_cs       <= 1'b0;
          r_rw       <= 1'b0;
          r_adress   <= 1'b0;
          r_data_out <= '0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cs       = r_cs;
  assign bus.rw       = r_rw;
  assign bus.adress   = r_adress;
  assign bus.data_out = r_data_out;

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule : aes_bus_master

// File: tb/tb_aes_bus_master.sv
// -----------------------------------------------------------------------------
// tb_aes_bus_master
//
// Purpose:
//   Self-checking bench for aes_bus_master. A transaction-level model tracks
//   the cycle offset since the accepted start and derives every bus output
//   from that offset; a compare process checks the DUT each cycle. Directed
//   scenarios add literal checks for the known-answer vector and boundaries.
//   Define AES_KEY_REUSE_EN to also exercise the key-reuse path.
// -----------------------------------------------------------------------------
module tb_aes_bus_master;

  localparam int W    = 12;
  localparam int RD0  = 34 + W;   // first read beat offset (full transaction)
  localparam int DONK = 50 + W;   // done offset (full transaction)

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         kr;
  logic [127:0] key;
  logic [127:0] msg;
  logic [127:0] tb_ct;
  logic         o_busy;
  logic         o_done;
  logic [127:0] o_result;

  always #5 clk = ~clk;

  aes_bus_master_if #(.BUS_W(8)) bus ();

  aes_bus_master #(.BUS_W(8), .WAIT_CYCLES(W)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
`ifdef AES_KEY_REUSE_EN
    .i_key_reuse(kr),
`endif
    .i_key_in   (key),
    .i_msg_in   (msg),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  bit           m_act = 0;
  int           m_k   = 0;
  bit           m_reuse = 0;
  logic [127:0] m_key, m_msg, m_ct;
  logic [127:0] m_res = '0;

  // Offset on the full-transaction timeline; a key-reuse run skips 16 beats.
  function automatic int eoff();
    return m_reuse ? m_k + 16 : m_k;
  endfunction

  function automatic logic [7:0] bytesel(input logic [127:0] v, input int i);
    return 8'((v >> (8 * (15 - i))) & 128'hFF);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_act = 0;
      m_k   = 0;
      m_res = '0;
    end else if (m_act) begin
      if (eoff() == DONK) m_act = 0;
      else begin
        m_k++;
        if (eoff() == DONK) m_res = m_ct;
      end
    end else if (start) begin
      m_act   = 1;
      m_k     = 1;
      m_key   = key;
      m_msg   = msg;
      m_ct    = tb_ct;
`ifdef AES_KEY_REUSE_EN
      m_reuse = kr;
`else
      m_reuse = 0;
`endif
    end
  end

  // Core model: ciphertext bytes on read beats, junk everywhere else.
  always @(posedge clk) begin
    #2;
    if (m_act && eoff() >= RD0 && eoff() <= RD0 + 15)
      bus.data_in = bytesel(m_ct, eoff() - RD0);
    else
      bus.data_in = 8'($urandom);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int   e;
    logic xcs, xrw, xad, xbusy, xdone;
    logic [7:0] xd;
    bit   rdwin;
    if (chk_en) begin
      xcs = 0; xrw = 0; xad = 0; xd = 0; xbusy = 0; xdone = 0; rdwin = 0; e = 0;
      if (m_act) begin
        e = eoff();
        xbusy = 1;
        if (e >= 1 && e <= 16) begin
          xcs = 1; xrw = 1; xad = 1; xd = bytesel(m_key, e - 1);
        end else if (e >= 17 && e <= 32) begin
          xcs = 1; xrw = 1; xd = bytesel(m_msg, e - 17);
        end else if (e == 33) begin
          xrw = 1;
        end else if (e >= RD0 && e <= RD0 + 15) begin
          xcs = 1; rdwin = 1;
        end else if (e == DONK) begin
          xdone = 1;
        end
      end
      check("cs",       bus.cs,       xcs);
      check("rw",       bus.rw,       xrw);
      check("adress",   bus.adress,   xad);
      check("data_out", bus.data_out, xd);
      check("busy",     o_busy,       xbusy);
      check("done",     o_done,       xdone);
      if (!rdwin) check("result", o_result, m_res);
      if (o_done === 1'b1) done_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int t0, input int expk, input string nm);
    int n = 0;
    while (o_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (o_done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done within 200 cycles want done at %0d", nm, expk);
    end else begin
      check({nm, "_latency"}, 128'(cyc - t0), 128'(expk));
    end
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] M1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C1 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  initial begin
    int t0;
    int d0;
    rst = 1; start = 0; kr = 0; key = '0; msg = '0; tb_ct = '0;
    tick();
    chk_en = 1;
    tick(); tick();
    rst = 0;
    repeat (5) tick();
    check("idle_result", o_result, 128'h0);
    check("idle_busy", o_busy, 1'b0);

    // T1: known-answer vector, inputs disturbed after acceptance
    key = K1; msg = M1; tb_ct = C1;
    start = 1; t0 = cyc;
    tick(); start = 0;                       // cycle 1
    check("t1_c1_data", bus.data_out, 8'h00);
    check("t1_c1_adress", bus.adress, 1'b1);
    repeat (3) tick();                       // cycle 4
    key = ~K1; msg = ~M1;
    repeat (12) tick();                      // cycle 16
    check("t1_c16_data", bus.data_out, 8'h0F);
    tick();                                  // cycle 17
    check("t1_c17_adress", bus.adress, 1'b0);
    repeat (15) tick();                      // cycle 32
    check("t1_c32_data", bus.data_out, 8'hFF);
    tick();                                  // cycle 33
    check("t1_c33_cs", bus.cs, 1'b0);
    wait_done(t0, 62, "t1");
    check("t1_result", o_result, C1);
    tick(); tick();

    // T2: starts while busy and in DONE ignored; start right after DONE accepted
    key = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    msg = 128'h0123456789ABCDEF_1122334455667788;
    tb_ct = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_C3C3;
    start = 1; t0 = cyc; d0 = done_cnt;
    tick(); start = 0;                       // cycle 1
    repeat (4) tick();                       // cycle 5
    start = 1; tick(); start = 0;            // cycle 6
    repeat (34) tick();                      // cycle 40
    start = 1; tick(); start = 0;            // cycle 41
    repeat (21) tick();                      // cycle 62
    check("t2_done_at_62", o_done, 1'b1);
    key = 128'h3C3C3C3C_11111111_22222222_33333333;
    msg = 128'h44444444_55555555_66666666_77777777;
    tb_ct = 128'h0F0E0D0C0B0A09080706050403020100;
    start = 1;                               // in DONE: ignored
    tick();                                  // IDLE: accepted
    t0 = cyc;
    tick(); start = 0;                       // T3 cycle 1
    check("t2_single_done", 128'(done_cnt - d0), 128'd1);
    check("t2_result_held", o_result, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_C3C3);
    check("t3_c1_busy", o_busy, 1'b1);

    // T3: reset during the 8th message beat
    repeat (23) tick();                      // cycle 24
    rst = 1;
    tick();                                  // cycle 25
    rst = 0;
    check("rst_mid_cs", bus.cs, 1'b0);
    check("rst_mid_busy", o_busy, 1'b0);
    check("rst_mid_result", o_result, 128'h0);
    tick(); tick();

    // T4: full transaction after the abort
    key = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    msg = 128'h3243F6A8885A308D313198A2E0370734;
    tb_ct = 128'h3925841D02DC09FBDC118597196A0B32;
    start = 1; t0 = cyc;
    tick(); start = 0;
    wait_done(t0, 62, "t4");
    check("t4_result", o_result, 128'h3925841D02DC09FBDC118597196A0B32);
    tick(); tick();

`ifdef AES_KEY_REUSE_EN
    // T5: key reuse skips the key phase
    kr = 1;
    key = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    msg = 128'h00112233445566778899AABBCCDDEEFF;
    tb_ct = 128'h8EA2B7CA516745BFEAFC49904B496089;
    start = 1; t0 = cyc;
    tick(); start = 0; kr = 0;
    check("t5_c1_adress", bus.adress, 1'b0);
    check("t5_c1_data", bus.data_out, 8'h00);
    wait_done(t0, 46, "t5");
    check("t5_result", o_result, 128'h8EA2B7CA516745BFEAFC49904B496089);
    tick(); tick();
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_aes_bus_master
